// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row synchronizer, frame classification
// and press/release debounce producing one-hot key levels plus a press pulse.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] ROW,
  output logic [2:0] COL,
  output logic [9:0] BUTTON,
  output logic       STAR,
  output logic       HASH,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [2:0]    col_q, col_d;
  logic [11:0]   raw_q, raw_d;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [11:0]   level_q, level_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          sample, frame_end;
  logic [11:0]   frame_raw;
  logic [3:0]    ones, single_key, cnt_inc, accept_key;
  logic          is_none, is_single, accept, release_key;

  // Raw vector bit index equals the key code of the key at (row, col).
  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    int v;
    if (r != 2'd3) v = int'(r) * 3 + int'(c) + 1;
    else if (c == 2'd0) v = 10;
    else if (c == 2'd1) v = 0;
    else v = 11;
    return 4'(v);
  endfunction

  always_comb begin
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    raw_d       = raw_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    frame_raw   = raw_q;
    ones        = 4'd0;
    single_key  = 4'd0;
    accept      = 1'b0;
    accept_key  = 4'd0;
    release_key = 1'b0;
    cnt_inc     = cnt_q + 4'd1;

    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (col_idx_q == 2'd2);
    dwell_d   = sample ? '0 : dwell_q + 1'b1;

    if (sample) begin
      for (int r = 0; r < 4; r++) frame_raw[key_of(2'(r), col_idx_q)] = ~row_s2_q[r];
      raw_d     = frame_raw;
      col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_d     = ~(3'b001 << col_idx_d);
    end

    for (int i = 0; i < 12; i++) begin
      if (frame_raw[i]) begin
        ones       = ones + 4'd1;
        single_key = 4'(i);
      end
    end
    is_none   = (ones == 4'd0);
    is_single = (ones == 4'd1);

    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = single_key;
            if (DB <= 4'd1) begin
              accept     = 1'b1;
              accept_key = single_key;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (is_single && single_key == cand_q) begin
            if (cnt_inc >= DB) begin
              accept     = 1'b1;
              accept_key = cand_q;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HELD: begin
          if (is_none) begin
            if (DB <= 4'd1) release_key = 1'b1;
            else begin
              state_d = REL_DB;
              cnt_d   = 4'd1;
            end
          end
        end
        default: begin
          if (is_none) begin
            if (cnt_inc >= DB) release_key = 1'b1;
            else cnt_d = cnt_inc;
          end else begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end

    // Only a fresh acceptance pulses KEY_VALID; a bounce back to HELD keeps levels silently.
    if (accept) begin
      state_d = HELD;
      cnt_d   = 4'd0;
      code_d  = accept_key;
      level_d = 12'd1 << accept_key;
      valid_d = 1'b1;
    end
    if (release_key) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      level_d = 12'd0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 3'b110;
      raw_q     <= 12'd0;
      state_q   <= IDLE;
      cand_q    <= 4'd0;
      cnt_q     <= 4'd0;
      level_q   <= 12'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
    end else begin
      row_s1_q  <= ROW;
      row_s2_q  <= row_s1_q;
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      raw_q     <= raw_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign COL       = col_q;
  assign BUTTON    = level_q[9:0];
  assign STAR      = level_q[10];
  assign HASH      = level_q[11];
  assign KEY_CODE  = code_q;
  assign KEY_VALID = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: frame-level key model drives rows, a reference model predicts
// accepted presses into a scoreboard queue that a KEY_VALID monitor drains.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int D = 3;
  localparam int FRAME = 12;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] ROW;
  logic [2:0] COL;
  logic [9:0] BUTTON;
  logic       STAR, HASH;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(D)) dut (
    .CLK(CLK), .RESET(RESET), .ROW(ROW), .COL(COL), .BUTTON(BUTTON),
    .STAR(STAR), .HASH(HASH), .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID)
  );

  always #5 CLK = ~CLK;

  // Layout row-major: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  int lay [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  logic [11:0] pressed;

  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!COL[c] && pressed[lay[r*3+c]]) ROW[r] = 1'b0;
  end

  int n_checks = 0, n_fail = 0, n_valid = 0, n_pushed = 0;
  int exp_q[$];

  // Reference model state: accepted key, streak length, last code.
  bit m_held;
  int m_key, m_cand, m_cnt, m_code;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] km(input int k);
    return 12'd1 << k;
  endfunction

  task automatic model_reset();
    m_held = 0; m_key = 0; m_cand = 0; m_cnt = 0; m_code = 0;
  endtask

  task automatic model_frame(input logic [11:0] mask);
    int n, k;
    n = $countones(mask);
    k = 0;
    for (int i = 0; i < 12; i++) if (mask[i]) k = i;
    if (!m_held) begin
      if (n == 1 && m_cnt > 0 && k == m_cand) m_cnt++;
      else if (n == 1 && m_cnt == 0) begin m_cand = k; m_cnt = 1; end
      else m_cnt = 0;
      if (m_cnt >= D) begin
        m_held = 1; m_key = m_cand; m_code = m_cand; m_cnt = 0;
        exp_q.push_back(m_cand);
        n_pushed++;
      end
    end else begin
      if (n == 0) m_cnt++; else m_cnt = 0;
      if (m_cnt >= D) begin m_held = 0; m_cnt = 0; end
    end
  endtask

  // One full scan frame with a stable key set, then model update and level checks.
  task automatic run_frame(input logic [11:0] mask);
    logic [11:0] exp_lvl;
    pressed = mask;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge CLK);
      #1;
      if (i == 4)  check("col_step1", int'(COL), 3'b101);
      if (i == 8)  check("col_step2", int'(COL), 3'b011);
      if (i == 12) check("col_step0", int'(COL), 3'b110);
    end
    model_frame(mask);
    exp_lvl = m_held ? km(m_key) : 12'd0;
    check("levels", int'({HASH, STAR, BUTTON}), int'(exp_lvl));
    check("key_code", int'(KEY_CODE), m_code);
  endtask

  task automatic run_frames(input logic [11:0] mask, input int n);
    for (int i = 0; i < n; i++) run_frame(mask);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"}, int'(COL), 3'b110);
    check({tag, "_levels"}, int'({HASH, STAR, BUTTON}), 0);
    check({tag, "_code"}, int'(KEY_CODE), 0);
    check({tag, "_valid"}, int'(KEY_VALID), 0);
  endtask

  // Asynchronous reset asserted at a random point inside the current frame.
  task automatic mid_reset();
    repeat ($urandom_range(1, 10)) @(posedge CLK);
    #3 RESET = 1'b1;
    #1 check_reset_values("mid_reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      check("exclusive", int'($countones({HASH, STAR, BUTTON}) <= 1), 1);
      if (KEY_VALID) begin
        n_valid++;
        check("valid_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          int k;
          k = exp_q.pop_front();
          $display("press accepted: code %0d (expected %0d)", KEY_CODE, k);
          check("valid_code", int'(KEY_CODE), k);
          check("valid_level", int'({HASH, STAR, BUTTON}), int'(km(k)));
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    pressed = 12'd0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_reset_values("reset");
    @(negedge CLK);
    RESET = 1'b0;

    run_frames(12'd0, 1);
    // Digit 5 press and release
    run_frames(km(5), 4);
    run_frames(12'd0, 4);
    // Star then hash
    run_frames(km(10), 4);
    run_frames(12'd0, 4);
    run_frames(km(11), 4);
    run_frames(12'd0, 4);
    // Bounce on 0, then a clean hold with a short dropout
    for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? km(0) : 12'd0);
    run_frames(km(0), 4);
    run_frames(12'd0, 2);
    run_frames(km(0), 3);
    run_frames(12'd0, 4);
    // Multi-key rejection and a second key added while held
    run_frames(km(1) | km(2), 5);
    run_frames(12'd0, 1);
    run_frames(km(7), 4);
    run_frames(km(7) | km(8), 3);
    run_frames(12'd0, 4);
    // Reset while 9 is held; 9 stays pressed through reset
    run_frames(km(9), 4);
    mid_reset();
    run_frames(km(9), 4);
    run_frames(12'd0, 4);

    // Random key traffic
    for (int f = 0; f < 40; f++) begin
      int choice, len;
      logic [11:0] mask;
      choice = $urandom_range(0, 3);
      len = $urandom_range(1, 5);
      case (choice)
        0: mask = 12'd0;
        3: mask = km($urandom_range(0, 11)) | km($urandom_range(0, 11));
        default: mask = km($urandom_range(0, 11));
      endcase
      run_frames(mask, len);
    end
    run_frames(12'd0, 4);

    @(negedge CLK);
    check("valid_count", n_valid, n_pushed);
    check("pending_presses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the door-lock design. It scans a 4x3 keypad, debounces it, and produces the one-hot `BUTTON[9:0]`, `STAR` and `HASH` levels that the lock top level consumes on its keypad inputs. It drives the keypad columns, reads the rows, and allows only one clean, stable key through at a time.

## Interface
- `SCAN_DIV`, default 4: clock cycles each column is driven. Must be ≥ 4.
- `DEBOUNCE`, default 3: consecutive identical frames required to accept a press or a release. Range 1–15.
- `CLK` input 1: single system clock, rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `ROW` input 4: keypad rows, active-low, externally pulled up, asynchronous to `CLK`.
- `COL` output 3: column drive, active-low one-hot.
- `BUTTON` output 10: one-hot digit level; bit n = digit n, held while the key is accepted.
- `STAR` output 1: `*` held level.
- `HASH` output 1: `#` held level.
- `KEY_CODE` output 4: last accepted key; 0–9 are digits, 10 = `*`, 11 = `#`.
- `KEY_VALID` output 1: one-cycle pulse when a press is accepted.

## Operation
- **Keypad layout:**
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = `*` 0 `#`
  - Columns are 0/1/2, left to right.
- **Input sync:** `ROW` passes through a 2-flop synchronizer before use.
- **Scan:**
  - A dwell counter runs 0..`SCAN_DIV`-1.
  - At wrap, the column index advances 0→1→2→0 and `COL` = ~(1<<index).
  - Synchronized rows are sampled on dwell = `SCAN_DIV`-1 into a 12-bit raw vector. A bit is set when its row reads 0.
- **Frame:** 3 columns = `3*SCAN_DIV` cycles. A frame ends at the sample of column 2. The frame is then classified:
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set.
  - MULTI: ≥ 2 bits set.
- **Frame FSM** (evaluated only at frame end):
  - **IDLE**
    - SINGLE(k) → PRESS_DB with candidate = k and count = 1.
    - Otherwise stay in IDLE.
  - **PRESS_DB**
    - SINGLE(candidate): count+1. When count reaches `DEBOUNCE` → HELD.
    - Any other frame class → IDLE.
    - When `DEBOUNCE` = 1, IDLE goes directly to HELD.
  - **HELD**
    - NONE → REL_DB with count = 1.
    - SINGLE of any key or MULTI → stay in HELD. A new key is never accepted without a full release first.
  - **REL_DB**
    - NONE: count+1. When count reaches `DEBOUNCE` → IDLE.
    - Any non-NONE frame → HELD.
- **Outputs:**
  - Registered.
  - Entering HELD: `KEY_CODE` = candidate; `KEY_VALID` = 1 for exactly one cycle; the matching `BUTTON` bit, `STAR` or `HASH` = 1.
  - The level stays asserted through HELD and REL_DB.
  - It clears on the edge that enters IDLE.
  - `KEY_CODE` retains its value after release.
- **Exclusivity:** at most one of the 12 level outputs is high at any time.
- **Reset:** asynchronous, mid-scan or mid-hold. Immediately after reset:
  - FSM = IDLE; counters = 0; column index = 0.
  - `COL` = 3'b110.
  - `BUTTON` = 0, `STAR` = 0, `HASH` = 0, `KEY_CODE` = 0, `KEY_VALID` = 0.
  - Scanning restarts on the first edge after deassertion.

## Timing
- `COL` changes on the edge at which dwell wraps. Each column is driven for exactly `SCAN_DIV` cycles.
- Sample point is `SCAN_DIV`-1 cycles after the column changes. This leaves ≥ 3 cycles to cover the 2-flop sync plus settling.
- **Press latency:** levels and `KEY_VALID` assert on the edge after the column-2 sample of the `DEBOUNCE`-th consecutive matching frame. From the first full matching frame this is `DEBOUNCE*3*SCAN_DIV` cycles, ±1 frame depending on press phase.
- **Release latency:** identical, counted in NONE frames.
- `KEY_VALID` fires once per accepted press and never on release.
- A bounce that breaks a streak restarts debounce. Counts never carry over between streaks.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3, so one frame = 12 cycles. The bench models the keypad by pulling the row low when the pressed key's column is low.

- **Reset values:** assert `RESET` mid-frame → `COL`=3'b110 and all outputs 0 in the same cycle. Deassert → `COL` steps 110→101→011→110 every 4 cycles.
- **Digit press/release:** hold '5' (row1, col1) stable → after 3 full frames `BUTTON`=10'b0000100000, `KEY_CODE`=5, `KEY_VALID` high 1 cycle. Release → `BUTTON`=0 after 3 NONE frames; `KEY_CODE` stays 5.
- **`*` and `#`:**
  - Press `*` → `STAR`=1, `KEY_CODE`=10, `BUTTON`=0.
  - Release, then press `#` → `HASH`=1, `KEY_CODE`=11.
  - Exactly two `KEY_VALID` pulses in total.
- **Bounce:**
  - Toggle '0' pressed/released every frame for 10 frames → no `KEY_VALID`, all levels 0.
  - Then hold '0' → accepted after 3 frames with `BUTTON`=10'b0000000001.
  - While held, inject 2 NONE frames then press again → no release and no second `KEY_VALID`.
- **Multi-key:** hold '1' and '2' together → no `KEY_VALID`, levels 0. During HELD of '7', add '8' → `BUTTON` stays bit 7. Release both → clears after 3 NONE frames.
- **Reset mid-hold:** while '9' is HELD, pulse `RESET` → `BUTTON`=0 immediately. With '9' still held, it is re-accepted 3 frames after deassertion with one new `KEY_VALID`.
